// File: rtl/agc_pwr_est.sv
// AGC power estimator: windowed mean of I^2+Q^2 converted to a 0.125 dB log code.
// Optional macro AGC_PWR_EST_PEAK_EN forces a full-scale code for windows that contained a clipped sample.
module agc_pwr_est #(
  parameter int DW    = 10,
  parameter int ACC_W = 2*DW+13
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 est_ena,
  input  logic [1:0]           win_sel,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [DW-1:0] din_q,
  input  logic                 din_val,
  output logic [8:0]           pwr_est_dB,
  output logic                 pwr_est_end,
  output logic                 pwr_est_busy
);

  localparam int PW = 2*DW;

  typedef enum logic [1:0] {ACC, NORM, OUT} state_t;

  state_t               state;
  logic signed [PW-1:0] din_i_x, din_q_x, sq_i, sq_q;
  logic [PW-1:0]        p_next, p;
  logic                 p_val;
  logic [ACC_W-1:0]     acc, acc_sum;
  logic [11:0]          cnt, last_cnt;
  logic [1:0]           win_r;
  logic [4:0]           shamt;
  logic                 win_end;
  logic [PW-1:0]        norm_load, norm_s;
  logic [4:0]           norm_e;
  logic [9:0]           code_raw;
  logic [8:0]           code_sat, code_fin;
  logic                 peak_win;

  assign din_i_x = PW'(din_i);
  assign din_q_x = PW'(din_q);
  assign sq_i    = din_i_x * din_i_x;
  assign sq_q    = din_q_x * din_q_x;
  assign p_next  = $unsigned(sq_i) + $unsigned(sq_q);

  // Stage 1: one registered power sample per accepted input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p     <= '0;
      p_val <= 1'b0;
    end else if (!est_ena) begin
      p_val <= 1'b0;
    end else begin
      p_val <= din_val;
      if (din_val)
        p <= p_next;
    end
  end

  always_comb begin
    last_cnt = 12'd63;
    case (win_r)
      2'd0:    last_cnt = 12'd63;
      2'd1:    last_cnt = 12'd255;
      2'd2:    last_cnt = 12'd1023;
      default: last_cnt = 12'd4095;
    endcase
  end

  assign acc_sum   = acc + ACC_W'(p);
  assign shamt     = 5'd6 + {2'b00, win_r, 1'b0};
  assign norm_load = PW'(acc_sum >> shamt);
  assign win_end   = p_val && (cnt == last_cnt);

  // Exponent counts down as the normaliser shifts; mantissa is the 3 bits under the leading one.
  assign code_raw = 10'(norm_e) * 10'd24 + 10'(norm_s[PW-2:PW-4]) * 10'd3;
  assign code_sat = (code_raw > 10'd511) ? 9'h1FF : code_raw[8:0];

`ifdef AGC_PWR_EST_PEAK_EN
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};

  logic pk_p, peak_flag;

  // Clip flag travels with its sample through stage 1, then accumulates per window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pk_p      <= 1'b0;
      peak_flag <= 1'b0;
      peak_win  <= 1'b0;
    end else if (!est_ena) begin
      pk_p      <= 1'b0;
      peak_flag <= 1'b0;
      peak_win  <= 1'b0;
    end else begin
      pk_p <= din_val && ((din_i == SMIN) || (din_i == SMAX) ||
                          (din_q == SMIN) || (din_q == SMAX));
      if (p_val) begin
        if (win_end) begin
          peak_win  <= peak_flag | pk_p;
          peak_flag <= 1'b0;
        end else begin
          peak_flag <= peak_flag | pk_p;
        end
      end
    end
  end

  assign code_fin = peak_win ? 9'h1FF : ((norm_s == '0) ? 9'd0 : code_sat);
`else
  assign peak_win = 1'b0;
  assign code_fin = (norm_s == '0) ? 9'd0 : code_sat;
`endif

  // Stage 2 accumulator plus the normaliser FSM; the last NORM step also drives the outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ACC;
      acc          <= '0;
      cnt          <= '0;
      win_r        <= 2'd0;
      norm_s       <= '0;
      norm_e       <= '0;
      pwr_est_dB   <= '0;
      pwr_est_end  <= 1'b0;
      pwr_est_busy <= 1'b0;
    end else if (!est_ena) begin
      state        <= ACC;
      acc          <= '0;
      cnt          <= '0;
      norm_s       <= '0;
      pwr_est_end  <= 1'b0;
      pwr_est_busy <= 1'b0;
    end else begin
      pwr_est_end <= 1'b0;
      if (cnt == '0)
        win_r <= win_sel;

      case (state)
        NORM: begin
          if (norm_s != '0 && !norm_s[PW-1]) begin
            norm_s <= norm_s << 1;
            norm_e <= norm_e - 5'd1;
          end else begin
            pwr_est_dB   <= code_fin;
            pwr_est_end  <= 1'b1;
            pwr_est_busy <= 1'b0;
            state        <= OUT;
          end
        end
        OUT:     state <= ACC;
        default: state <= ACC;
      endcase

      if (p_val) begin
        if (win_end) begin
          acc          <= '0;
          cnt          <= '0;
          norm_s       <= norm_load;
          norm_e       <= 5'(PW-1);
          state        <= NORM;
          pwr_est_busy <= 1'b1;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 12'd1;
        end
      end
    end
  end

endmodule
